// File: rtl/basics_top.sv
// Starter-board top: tick-paced LED counter / bouncing scanner, debounced mode button, peripherals parked idle.
// Inputs pass 2 sync stages; LED is registered 1 cycle after the pattern state; no flow control.
module basics_top #(
  parameter int TICK_DIV        = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic [1:0]  KEY,
  input  logic [3:0]  SW,
  output logic [7:0]  LED,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic [1:0]  DRAM_DQM,
  output logic        DRAM_CAS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_CS_N,
  output logic        DRAM_CKE,
  output logic        DRAM_CLK,
  inout  wire  [15:0] DRAM_DQ,
  output logic        EPCS_ASDO,
  output logic        EPCS_DCLK,
  output logic        EPCS_NCSO,
  input  logic        EPCS_DATA0,
  output logic        G_SENSOR_CS_N,
  input  logic        G_SENSOR_INT,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT,
  output logic        ADC_CS_N,
  output logic        ADC_SADDR,
  output logic        ADC_SCLK,
  input  logic        ADC_SDAT,
  inout  wire  [12:0] GPIO_2,
  input  logic [2:0]  GPIO_2_IN
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  logic rst_n;
  assign rst_n = KEY[0];

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic          btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic          db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          mode_q, mode_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    pos_q, pos_d;
  logic          dir_q, dir_d;   // 0 = walking up, 1 = walking down
  logic [7:0]    led_q, led_d;
  logic          tick, press;
  logic [7:0]    disp;

  always_comb begin
    presc_d  = presc_q + 1'b1;
    tick     = 1'b0;
    if (presc_q == TICK_LAST) begin
      tick    = 1'b1;
      presc_d = '0;
    end

    sw_s1_d  = SW[2:0];
    sw_s2_d  = sw_s1_q;
    btn_s1_d = KEY[1];
    btn_s2_d = btn_s1_q;

    // Any sample matching the accepted state restarts the stability window.
    db_d     = db_q;
    db_cnt_d = '0;
    if (btn_s2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = btn_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    press = db_q & ~db_d;

    mode_d = mode_q;
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    if (press) begin
      // A tick landing with the press is dropped; the new mode starts clean.
      mode_d = ~mode_q;
      if (mode_q) begin
        cnt_d = '0;
      end else begin
        pos_d = '0;
        dir_d = 1'b0;
      end
    end else if (tick && !sw_s2_q[0]) begin
      if (!mode_q) begin
        cnt_d = sw_s2_q[2] ? cnt_q - 8'd1 : cnt_q + 8'd1;
      end else if (!dir_q) begin
        if (pos_q == 3'd7) begin
          dir_d = 1'b1;
          pos_d = 3'd6;
        end else begin
          pos_d = pos_q + 3'd1;
        end
      end else begin
        if (pos_q == 3'd0) begin
          dir_d = 1'b0;
          pos_d = 3'd1;
        end else begin
          pos_d = pos_q - 3'd1;
        end
      end
    end

    disp  = mode_q ? (8'd1 << pos_q) : cnt_q;
    led_d = disp ^ {8{sw_s2_q[1]}};
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
      db_q     <= 1'b1;
      db_cnt_q <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      led_q    <= '0;
    end else begin
      presc_q  <= presc_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      led_q    <= led_d;
    end
  end

  assign LED = led_q;

  assign DRAM_ADDR     = '0;
  assign DRAM_BA       = '0;
  assign DRAM_DQM      = 2'b11;
  assign DRAM_CAS_N    = 1'b1;
  assign DRAM_RAS_N    = 1'b1;
  assign DRAM_WE_N     = 1'b1;
  assign DRAM_CS_N     = 1'b1;
  assign DRAM_CKE      = 1'b0;
  assign DRAM_CLK      = 1'b0;
  assign DRAM_DQ       = 16'bz;
  assign EPCS_ASDO     = 1'b0;
  assign EPCS_DCLK     = 1'b0;
  assign EPCS_NCSO     = 1'b1;
  assign G_SENSOR_CS_N = 1'b1;
  assign I2C_SCLK      = 1'b1;
  assign I2C_SDAT      = 1'bz;
  assign ADC_CS_N      = 1'b1;
  assign ADC_SADDR     = 1'b0;
  assign ADC_SCLK      = 1'b1;
  assign GPIO_2        = 13'bz;

  logic unused_inputs;
  assign unused_inputs = ^{EPCS_DATA0, G_SENSOR_INT, ADC_SDAT, GPIO_2_IN, SW[3]};

endmodule

// File: tb/tb_basics_top.sv
// Randomized self-checking bench for basics_top against a sequence-level LED pattern model.
module tb_basics_top;
  localparam int TD = 4;
  localparam int DC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  key;
  logic [3:0]  sw;
  logic        epcs_data0, g_int, adc_sdat;
  logic [2:0]  gpio_in;
  wire  [7:0]  led;
  wire  [12:0] dram_addr;
  wire  [1:0]  dram_ba, dram_dqm;
  wire         dram_cas_n, dram_ras_n, dram_we_n, dram_cs_n, dram_cke, dram_clk;
  wire         epcs_asdo, epcs_dclk, epcs_ncso, gs_cs_n, i2c_sclk;
  wire         adc_cs_n, adc_saddr, adc_sclk;
  wire  [15:0] dram_dq;
  wire         i2c_sdat;
  wire  [12:0] gpio_2;

  // The bench drives the bidirectional pins; the design must leave them floating.
  assign dram_dq  = 16'hA5C3;
  assign i2c_sdat = 1'b0;
  assign gpio_2   = 13'h0A5A;

  basics_top #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DC)) dut (
    .CLOCK_50(clk), .KEY(key), .SW(sw), .LED(led),
    .DRAM_ADDR(dram_addr), .DRAM_BA(dram_ba), .DRAM_DQM(dram_dqm),
    .DRAM_CAS_N(dram_cas_n), .DRAM_RAS_N(dram_ras_n), .DRAM_WE_N(dram_we_n),
    .DRAM_CS_N(dram_cs_n), .DRAM_CKE(dram_cke), .DRAM_CLK(dram_clk), .DRAM_DQ(dram_dq),
    .EPCS_ASDO(epcs_asdo), .EPCS_DCLK(epcs_dclk), .EPCS_NCSO(epcs_ncso), .EPCS_DATA0(epcs_data0),
    .G_SENSOR_CS_N(gs_cs_n), .G_SENSOR_INT(g_int), .I2C_SCLK(i2c_sclk), .I2C_SDAT(i2c_sdat),
    .ADC_CS_N(adc_cs_n), .ADC_SADDR(adc_saddr), .ADC_SCLK(adc_sclk), .ADC_SDAT(adc_sdat),
    .GPIO_2(gpio_2), .GPIO_2_IN(gpio_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Pattern model: counter value, or index into the 14-step bounce sequence.
  bit m_mode, m_down, m_inv;
  int m_cnt, m_k;

  function automatic logic [7:0] m_disp();
    int pos;
    logic [7:0] v;
    if (m_mode) begin
      pos = (m_k <= 7) ? m_k : 14 - m_k;
      v   = 8'd1 << pos;
    end else begin
      v = m_cnt[7:0];
    end
    return v ^ {8{m_inv}};
  endfunction

  function automatic void m_step();
    if (m_mode) m_k = (m_k + 1) % 14;
    else        m_cnt = m_down ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
  endfunction

  task automatic wait_change(input int lim, output logic [7:0] v, output int cyc, output bit ok);
    logic [7:0] prev;
    prev = led;
    cyc  = 0;
    ok   = 1'b0;
    while (!ok && cyc < lim) begin
      @(negedge clk);
      cyc++;
      ok = (led !== prev);
    end
    v = led;
  endtask

  task automatic wait_value(input logic [7:0] want, input int lim, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < lim) begin
      @(negedge clk);
      cyc++;
      ok = (led === want);
    end
  endtask

  initial begin
    epcs_data0 = 1'b0; g_int = 1'b0; adc_sdat = 1'b0; gpio_in = '0;
    forever begin
      @(negedge clk);
      epcs_data0 = 1'($urandom);
      g_int      = 1'($urandom);
      adc_sdat   = 1'($urandom);
      gpio_in    = 3'($urandom);
    end
  end

  task automatic test_reset();
    logic [31:0] obs [13];
    logic [31:0] exp [13];
    string       nm  [13];
    key = 2'b11;
    sw  = 4'b0000;
    #1 key = 2'b10;
    repeat (100) begin
      @(negedge clk);
      sw[3] = 1'($urandom);
    end
    obs[0]  = 32'(led);                                         exp[0]  = 32'h00;   nm[0]  = "reset_led";
    obs[1]  = 32'({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n}); exp[1] = 32'hF;  nm[1]  = "dram_cmd";
    obs[2]  = 32'({dram_cke, dram_clk});                        exp[2]  = 32'h0;    nm[2]  = "dram_cke_clk";
    obs[3]  = 32'(dram_addr);                                   exp[3]  = 32'h0;    nm[3]  = "dram_addr";
    obs[4]  = 32'(dram_ba);                                     exp[4]  = 32'h0;    nm[4]  = "dram_ba";
    obs[5]  = 32'(dram_dqm);                                    exp[5]  = 32'h3;    nm[5]  = "dram_dqm";
    obs[6]  = 32'({epcs_ncso, epcs_dclk, epcs_asdo});           exp[6]  = 32'h4;    nm[6]  = "epcs";
    obs[7]  = 32'({gs_cs_n, i2c_sclk});                         exp[7]  = 32'h3;    nm[7]  = "gsensor_i2c";
    obs[8]  = 32'({adc_cs_n, adc_sclk, adc_saddr});             exp[8]  = 32'h6;    nm[8]  = "adc";
    obs[9]  = 32'(dram_dq);                                     exp[9]  = 32'hA5C3; nm[9]  = "dram_dq_float";
    obs[10] = 32'(i2c_sdat);                                    exp[10] = 32'h0;    nm[10] = "i2c_sdat_float";
    obs[11] = 32'(gpio_2);                                      exp[11] = 32'h0A5A; nm[11] = "gpio_2_float";
    obs[12] = 32'(led);                                         exp[12] = 32'h00;   nm[12] = "reset_led_hold";
    for (int i = 0; i < 13; i++) begin
      n_checks++;
      if (obs[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL %s: got %0h want %0h", nm[i], obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_count();
    logic [7:0] v; int cyc; bit ok;
    @(negedge clk);
    #2 key[0] = 1'b1;
    m_mode = 0; m_cnt = 0; m_k = 0; m_down = 0; m_inv = 0;
    for (int i = 0; i < 256; i++) begin
      m_step();
      wait_change(3*TD+2, v, cyc, ok);
      n_checks++;
      if (!ok || v !== m_disp()) begin
        n_fail++;
        $display("FAIL count_val step %0d: got %02h want %02h", i, v, m_disp());
      end
      n_checks++;
      if (cyc != ((i == 0) ? TD+1 : TD)) begin
        n_fail++;
        $display("FAIL count_gap step %0d: got %0d cycles want %0d", i, cyc, (i == 0) ? TD+1 : TD);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v; int cyc; bit ok;
    for (int i = 0; i < 42; i++) begin
      m_step();
      wait_change(3*TD+2, v, cyc, ok);
      n_checks++;
      if (!ok || v !== m_disp()) begin
        n_fail++;
        $display("FAIL midrst_pre step %0d: got %02h want %02h", i, v, m_disp());
      end
    end
    #1 key[0] = 1'b0;
    #1;
    n_checks++;
    if (led !== 8'h00) begin
      n_fail++;
      $display("FAIL async_clear: got %02h want 00", led);
    end
    #2 key[0] = 1'b1;
    m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      m_step();
      wait_change(3*TD+2, v, cyc, ok);
      n_checks++;
      if (!ok || v !== m_disp() || (i == 0 && cyc != TD+1)) begin
        n_fail++;
        $display("FAIL midrst_restart step %0d: got %02h after %0d cycles want %02h", i, v, cyc, m_disp());
      end
    end
  endtask

  task automatic test_button();
    logic [7:0] v; int cyc; bit ok;
    key[1] = 1'b0;
    wait_value(8'h01, 30, cyc, ok);
    n_checks++;
    if (!ok || cyc < 10 || cyc > 12) begin
      n_fail++;
      $display("FAIL press_toggle: got LED %02h at cycle %0d want 01 at cycle 10..12", led, cyc);
    end
    m_mode = 1; m_k = 0;
    for (int i = 0; i < 182; i++) begin
      if (i == 172) key[1] = 1'b1;
      m_step();
      wait_change(3*TD+2, v, cyc, ok);
      n_checks++;
      if (!ok || v !== m_disp() || (i > 0 && cyc != TD)) begin
        n_fail++;
        $display("FAIL scan step %0d: got %02h after %0d cycles want %02h", i, v, cyc, m_disp());
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] v; int cyc; bit ok;
    fork
      begin
        repeat (3) begin
          key[1] = 1'b0;
          repeat ($urandom_range(2, DC-2)) @(negedge clk);
          key[1] = 1'b1;
          repeat (5) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          m_step();
          wait_change(3*TD+2, v, cyc, ok);
          n_checks++;
          if (!ok || v !== m_disp()) begin
            n_fail++;
            $display("FAIL bounce_hold step %0d: got %02h want %02h", i, v, m_disp());
          end
        end
      end
    join
    fork
      begin
        key[1] = 1'b0;
        repeat (20) @(negedge clk);
        key[1] = 1'b1;
      end
      begin
        wait_value(8'h00, 30, cyc, ok);
        n_checks++;
        if (!ok) begin
          n_fail++;
          $display("FAIL long_press: got %02h want 00", led);
        end
        m_mode = 0; m_cnt = 0;
        for (int i = 0; i < 7; i++) begin
          m_step();
          wait_change(3*TD+2, v, cyc, ok);
          n_checks++;
          if (!ok || v !== m_disp()) begin
            n_fail++;
            $display("FAIL single_toggle step %0d: got %02h want %02h", i, v, m_disp());
          end
        end
      end
    join
  endtask

  task automatic test_switches();
    logic [7:0] v; int cyc; bit ok; int nt;
    sw[0] = 1'b1;
    sw[3] = 1'($urandom);
    nt = $urandom_range(10, 14);
    for (int j = 0; j < nt; j++) begin
      repeat (TD) @(negedge clk);
      n_checks++;
      if (led !== m_disp()) begin
        n_fail++;
        $display("FAIL pause_hold tick %0d: got %02h want %02h", j, led, m_disp());
      end
    end
    sw[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sw[1] = (k == 0);
      m_inv = (k == 0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (led !== m_disp()) begin
        n_fail++;
        $display("FAIL invert_%0d: got %02h want %02h", k, led, m_disp());
      end
      for (int i = 0; i < 3; i++) begin
        m_step();
        wait_change(3*TD+2, v, cyc, ok);
        n_checks++;
        if (!ok || v !== m_disp()) begin
          n_fail++;
          $display("FAIL invert_step %0d/%0d: got %02h want %02h", k, i, v, m_disp());
        end
      end
    end
    sw[2] = 1'b1;
    m_down = 1;
    nt = m_cnt + $urandom_range(2, 6);
    for (int i = 0; i < nt + 2; i++) begin
      if (i == nt) begin
        sw[2] = 1'b0;
        m_down = 0;
      end
      m_step();
      wait_change(3*TD+2, v, cyc, ok);
      n_checks++;
      if (!ok || v !== m_disp() || cyc != TD) begin
        n_fail++;
        $display("FAIL down_step %0d: got %02h after %0d cycles want %02h", i, v, cyc, m_disp());
      end
    end
  endtask

  task automatic test_coincident();
    logic [7:0] v; int cyc; bit ok;
    for (int r = 0; r < 2; r++) begin
      // Called just after an LED change, so the next-but-two tick lands on the debounced press.
      @(negedge clk);
      key[1] = 1'b0;
      m_mode = ~m_mode; m_cnt = 0; m_k = 0;
      repeat (11) @(negedge clk);
      n_checks++;
      if (led !== m_disp()) begin
        n_fail++;
        $display("FAIL coincide_init %0d: got %02h want %02h", r, led, m_disp());
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (led !== m_disp()) begin
        n_fail++;
        $display("FAIL coincide_nostep %0d: got %02h want %02h", r, led, m_disp());
      end
      @(negedge clk);
      m_step();
      n_checks++;
      if (led !== m_disp()) begin
        n_fail++;
        $display("FAIL coincide_next %0d: got %02h want %02h", r, led, m_disp());
      end
      key[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        m_step();
        wait_change(3*TD+2, v, cyc, ok);
        n_checks++;
        if (!ok || v !== m_disp() || cyc != TD) begin
          n_fail++;
          $display("FAIL coincide_run %0d/%0d: got %02h after %0d cycles want %02h", r, i, v, cyc, m_disp());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_reset_mid();
    test_button();
    test_bounce();
    test_switches();
    test_coincident();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
